// File: rtl/tx_intf_pkg.sv
// Shared types and constants for the multi-source PL-to-m_axis bridge.
package tx_intf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    XFER  = 2'b01,
    DRAIN = 2'b10
  } state_t;

  localparam logic [1:0] MODE_END   = 2'b00;
  localparam logic [1:0] MODE_START = 2'b01;
  localparam logic [1:0] MODE_EXT   = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;

  localparam logic [15:0] CNT_SAT = 16'hFFFF;

endpackage

// File: rtl/tx_intf_sync_fifo.sv
// Synchronous FIFO with an extra pointer MSB to tell full from empty;
// a write is allowed at full when a read pops in the same cycle.
module tx_intf_sync_fifo #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]  wr_ptr_q;
  logic [ADDR_W:0]  rd_ptr_q;
  logic             wr_ok;
  logic             rd_ok;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign rd_ok     = rd_en_i && !empty_o;
  assign wr_ok     = wr_en_i && (!full_o || rd_ok);
  assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
    end
  end

  // Storage is data only; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/tx_intf_pl_to_m_axis_mc.sv
// Selects one PL source into a FIFO and, on an edge-detected trigger,
// streams exactly trans_len beats toward the m_axis master under fulln backpressure.
module tx_intf_pl_to_m_axis_mc
  import tx_intf_pkg::*;
#(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int NUM_SRC                = 2,
  parameter int SRC_SEL_WIDTH          = 1,
  parameter int FIFO_ADDR_WIDTH        = 4,
  parameter int TRANS_LEN_WIDTH        = 14
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [1:0]                            start_1trans_mode,
  input  logic                                  start_1trans_ext_trigger,
  input  logic                                  tx_start_from_acc,
  input  logic                                  tx_end_from_acc,
  input  logic [SRC_SEL_WIDTH-1:0]              src_sel,
  input  logic [TRANS_LEN_WIDTH-1:0]            trans_len,
  input  logic [NUM_SRC*C_M00_AXIS_TDATA_WIDTH-1:0] data_in,
  input  logic [NUM_SRC-1:0]                    data_in_valid,
  input  logic                                  fulln_from_m_axis,
  output logic                                  start_1trans_to_m_axis,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     data_to_m_axis,
  output logic                                  data_ready_to_m_axis,
  output logic                                  busy,
  output logic [15:0]                           fifo_overflow_cnt,
  output logic [15:0]                           trig_miss_cnt
);

  localparam int W = C_M00_AXIS_TDATA_WIDTH;

  state_t                     state_q;
  logic                       start_s1_q, start_s2_q;
  logic                       end_s1_q, end_s2_q;
  logic                       ext_s1_q, ext_s2_q;
  logic [SRC_SEL_WIDTH-1:0]   src_sel_q;
  logic [TRANS_LEN_WIDTH-1:0] len_q;
  logic [TRANS_LEN_WIDTH-1:0] beat_cnt_q;
  logic                       start_pulse_q;
  logic [15:0]                ovf_cnt_q;
  logic [15:0]                miss_cnt_q;

  logic         rise_start, rise_end, rise_ext, trig_evt;
  logic         src_vld;
  logic [W-1:0] src_data;
  logic         fifo_full, fifo_empty;
  logic         wr_req, wr_en, rd_en, ovf;
  logic [W-1:0] fifo_head;

  // Trigger stage: inputs are sampled once, edges come from the sampled pair.
  assign rise_start = start_s1_q & ~start_s2_q;
  assign rise_end   = end_s1_q   & ~end_s2_q;
  assign rise_ext   = ext_s1_q   & ~ext_s2_q;

  always_comb begin
    trig_evt = 1'b0;
    case (start_1trans_mode)
      MODE_END:   trig_evt = rise_end;
      MODE_START: trig_evt = rise_start;
      MODE_EXT:   trig_evt = rise_ext;
      MODE_BOTH:  trig_evt = rise_start | rise_end;
      default:    trig_evt = 1'b0;
    endcase
  end

  // Source mux: an out-of-range index leaves src_vld low.
  always_comb begin
    src_vld  = 1'b0;
    src_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel_q == SRC_SEL_WIDTH'(k)) begin
        src_vld  = data_in_valid[k];
        src_data = data_in[k*W +: W];
      end
    end
  end

  assign rd_en  = (state_q == XFER) && !fifo_empty && fulln_from_m_axis;
  assign wr_req = src_vld && (state_q != DRAIN);
  assign wr_en  = wr_req && (!fifo_full || rd_en);
  assign ovf    = wr_req && fifo_full && !rd_en;

  tx_intf_sync_fifo #(
    .WIDTH  (W),
    .ADDR_W (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (src_data),
    .rd_en_i   (rd_en),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Control stage: FSM, start pulse and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      start_s1_q    <= 1'b0;
      start_s2_q    <= 1'b0;
      end_s1_q      <= 1'b0;
      end_s2_q      <= 1'b0;
      ext_s1_q      <= 1'b0;
      ext_s2_q      <= 1'b0;
      src_sel_q     <= '0;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      start_pulse_q <= 1'b0;
      ovf_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      start_s1_q    <= tx_start_from_acc;
      start_s2_q    <= start_s1_q;
      end_s1_q      <= tx_end_from_acc;
      end_s2_q      <= end_s1_q;
      ext_s1_q      <= start_1trans_ext_trigger;
      ext_s2_q      <= ext_s1_q;
      start_pulse_q <= 1'b0;
      if (ovf && ovf_cnt_q != CNT_SAT) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          src_sel_q <= src_sel;
          if (trig_evt) begin
            if (trans_len != '0) begin
              start_pulse_q <= 1'b1;
              len_q         <= trans_len;
              beat_cnt_q    <= '0;
              state_q       <= XFER;
            end else if (miss_cnt_q != CNT_SAT) begin
              miss_cnt_q <= miss_cnt_q + 16'd1;
            end
          end
        end
        XFER: begin
          if (trig_evt && miss_cnt_q != CNT_SAT) miss_cnt_q <= miss_cnt_q + 16'd1;
          if (rd_en) begin
            beat_cnt_q <= beat_cnt_q + TRANS_LEN_WIDTH'(1);
            if (beat_cnt_q == len_q - TRANS_LEN_WIDTH'(1)) state_q <= DRAIN;
          end
        end
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_1trans_to_m_axis = start_pulse_q;
  assign data_ready_to_m_axis   = rd_en;
  assign data_to_m_axis         = fifo_empty ? '0 : fifo_head;
  assign busy                   = (state_q != IDLE);
  assign fifo_overflow_cnt      = ovf_cnt_q;
  assign trig_miss_cnt          = miss_cnt_q;

endmodule
